// File: rtl/oled_fb_pkg.sv
// Shared constants for the OLED frame buffer: colour formats, display modes, bar palette.
package oled_fb_pkg;

  localparam int COLOR_16   = 16;
  localparam int COLOR_8    = 8;
  localparam int COLOR_MONO = 1;

  typedef enum logic [1:0] {
    MODE_BUF   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BLACK = 2'd3
  } fb_mode_e;

  // Pixel format {b[5:0],g[4:0],r[4:0]}; index 0 is the leftmost bar.
  localparam logic [7:0][15:0] BAR_COLOR = {
    16'h0000,  // 7 black
    16'hFC00,  // 6 blue
    16'h001F,  // 5 red
    16'hFC1F,  // 4 magenta
    16'h03E0,  // 3 green
    16'hFFE0,  // 2 cyan
    16'h03FF,  // 1 yellow
    16'hFFFF   // 0 white
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/oled_fb_dpram.sv
// Two-bank simple dual-port pixel RAM; the bank bit selects the upper or lower half.
module oled_fb_dpram #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2*DEPTH];
  logic [AW:0] widx, ridx;

  assign widx = wbank ? (AW+1)'(DEPTH) + {1'b0, waddr} : {1'b0, waddr};
  assign ridx = rbank ? (AW+1)'(DEPTH) + {1'b0, raddr} : {1'b0, raddr};

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/oled_frame_buffer.sv
// Ping-pong frame buffer: writer fills the back bank, display reads the front bank
// with a fixed 2-cycle latency; banks swap only on frame_sync after a full frame.
module oled_frame_buffer
  import oled_fb_pkg::*;
#(
  parameter int X_SIZE      = 80,
  parameter int Y_SIZE      = 60,
  parameter int COLOR_BITS  = 16,
  parameter int MONO_THRESH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sof,
  input  logic [15:0]           wr_data,
  input  logic                  freeze,
  input  logic [1:0]            mode,
  input  logic [6:0]            rd_x,
  input  logic [6:0]            rd_y,
  input  logic                  rd_en,
  input  logic                  frame_sync,
  output logic [COLOR_BITS-1:0] rd_color,
  output logic                  frame_swapped
);

  localparam int         NPIX    = X_SIZE * Y_SIZE;
  localparam int         AW      = clog2(NPIX);
  localparam logic [6:0] XS      = 7'(X_SIZE);
  localparam logic [6:0] YS      = 7'(Y_SIZE);
  localparam logic [6:0] THRESH7 = 7'(MONO_THRESH);

  // ---------------- write side / bank control ----------------
  logic          wb, pending, out_of_reset;
  logic [AW-1:0] wr_addr, wr_addr_eff;
  logic          wr_fire, wr_last, swap;

  // pending blocks further accepts, so a completed frame can never be overwritten
  assign wr_ready    = ~pending & ~freeze & out_of_reset;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_addr_eff = wr_sof ? '0 : wr_addr;
  assign wr_last     = (wr_addr_eff == AW'(NPIX - 1));
  assign swap        = frame_sync & pending & ~freeze;

  // Write counter, frame-complete flag and bank swap; swap and accept are exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset  <= 1'b0;
      wb            <= 1'b0;
      pending       <= 1'b0;
      wr_addr       <= '0;
      frame_swapped <= 1'b0;
    end else begin
      out_of_reset  <= 1'b1;
      frame_swapped <= swap;
      if (swap) begin
        wb      <= ~wb;
        pending <= 1'b0;
      end
      if (wr_fire) begin
        wr_addr <= wr_last ? '0 : wr_addr_eff + 1'b1;
        if (wr_last) pending <= 1'b1;
      end
    end
  end

  // ---------------- read side ----------------
  logic          in_range;
  logic [AW-1:0] lin, rd_addr;
  logic [15:0]   pat_pix, ram_q;

  assign in_range = (rd_x < XS) & (rd_y < YS);
  assign lin      = AW'(rd_y) * AW'(X_SIZE) + AW'(rd_x);
  assign rd_addr  = in_range ? lin : '0;

  oled_fb_dpram #(.DEPTH(NPIX), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .wbank (wb),
    .waddr (wr_addr_eff),
    .wdata (wr_data),
    .rbank (~wb),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Test pattern pixel, computed in cycle 0 so it lines up with the RAM read.
  always_comb begin
    pat_pix = '0;
    case (fb_mode_e'(mode))
      MODE_BARS:  pat_pix = BAR_COLOR[3'({rd_x, 3'b000} / 10'(X_SIZE))];
      MODE_CHECK: pat_pix = (rd_x[3] ^ rd_y[3]) ? 16'hFFFF : 16'h0000;
      default:    pat_pix = '0;
    endcase
  end

  logic        s1_vld;
  logic [1:0]  s1_mode;
  logic [15:0] s1_pat, s1_pix;

  // Stage 1: carry request qualifier, mode and pattern alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_mode <= '0;
      s1_pat  <= '0;
    end else begin
      s1_vld  <= rd_en & in_range;
      s1_mode <= mode;
      s1_pat  <= pat_pix;
    end
  end

  assign s1_pix = !s1_vld                 ? 16'h0000 :
                  (s1_mode == MODE_BUF)   ? ram_q    : s1_pat;

  // Output format conversion.
  logic [COLOR_BITS-1:0] conv;
  if (COLOR_BITS == COLOR_16) begin : g_c16
    assign conv = s1_pix;
  end else if (COLOR_BITS == COLOR_8) begin : g_c8
    assign conv = {s1_pix[4:2], s1_pix[9:7], s1_pix[15:14]};
  end else begin : g_c1
    logic [6:0] luma;
    // r + g + b[5:1]; at most 93 so 7 bits never overflow
    assign luma = {2'b00, s1_pix[4:0]} + {2'b00, s1_pix[9:5]} + {2'b00, s1_pix[15:11]};
    assign conv = (luma >= THRESH7);
  end

  // Stage 2: registered output pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_color <= '0;
    else        rd_color <= conv;
  end

endmodule
